servant_wb_rr_arbiter: RTL and testbench

//   Round-robin Wishbone arbiter that shares the single servant RAM port among N

---
 rtl/servant_wb_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_servant_wb_rr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/servant_wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS classic masters.
// One single-beat transfer per grant, with an optional no-ack timeout that returns an error.
module servant_wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic [NUM_MASTERS-1:0]    i_m_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_we,
  input  logic [NUM_MASTERS*32-1:0] i_m_adr,
  input  logic [NUM_MASTERS*32-1:0] i_m_dat,
  input  logic [NUM_MASTERS*4-1:0]  i_m_sel,
  output logic [31:0]               o_m_rdt,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic [31:0]               o_s_adr,
  output logic [31:0]               o_s_dat,
  output logic [3:0]                o_s_sel,
  output logic                      o_s_we,
  output logic                      o_s_cyc,
  input  logic [31:0]               i_s_rdt,
  input  logic                      i_s_ack
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IdxW-1:0] LastRst = IdxW'(NUM_MASTERS - 1);
  localparam logic [TO_WIDTH-1:0] ToLast = (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IdxW-1:0]        last_q;
  logic [IdxW-1:0]        gidx_q;
  logic [TO_WIDTH-1:0]    cnt_q;

  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  logic [NUM_MASTERS-1:0] win_oh;
  logic                   cyc_g;
  logic                   ack_hit;
  logic                   to_hit;

  // First requester after the last served master, wrapping around.
  always_comb begin
    int unsigned k;
    k         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      k = (32'(last_q) + i) % NUM_MASTERS;
      if (!win_found && i_m_cyc[k]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(k);
      end
    end
    win_oh = NUM_MASTERS'(win_found) << win_idx;
  end

  // grant_q is zero in IDLE, so the AND-OR mux drives all slave signals low there.
  always_comb begin
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        o_s_adr = o_s_adr | i_m_adr[k*32 +: 32];
        o_s_dat = o_s_dat | i_m_dat[k*32 +: 32];
        o_s_sel = o_s_sel | i_m_sel[k*4 +: 4];
      end
    end
  end

  assign cyc_g   = |(grant_q & i_m_cyc);
  assign o_s_cyc = cyc_g;
  assign o_s_we  = |(grant_q & i_m_we);
  assign o_grant = grant_q;

  assign ack_hit = (state_q == StGrant) && cyc_g && i_s_ack;
  assign to_hit  = (TIMEOUT != 0) && (state_q == StGrant) && cyc_g && !i_s_ack &&
                   (cnt_q == ToLast);

  assign o_m_ack = {NUM_MASTERS{ack_hit | to_hit}} & grant_q;
  assign o_m_err = {NUM_MASTERS{to_hit}} & grant_q;
  assign o_m_rdt = ack_hit ? i_s_rdt : '0;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastRst;
      gidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (win_found) begin
            state_q <= StGrant;
            grant_q <= win_oh;
            gidx_q  <= win_idx;
          end
        end
        StGrant: begin
          if (!cyc_g) begin
            // Master abandoned the cycle: no ack, priority left where it was.
            state_q <= StIdle;
            grant_q <= '0;
            cnt_q   <= '0;
          end else if (ack_hit || to_hit) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= gidx_q;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + TO_WIDTH'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_wb_rr_arbiter.sv
// Directed, table-driven bench for servant_wb_rr_arbiter (3 masters, TIMEOUT=4).
module tb_servant_wb_rr_arbiter;

  localparam int unsigned N = 3;

  logic          clk;
  logic          nrst;
  logic [N-1:0]  m_cyc;
  logic [N-1:0]  m_we;
  logic [N*32-1:0] m_adr;
  logic [N*32-1:0] m_dat;
  logic [N*4-1:0]  m_sel;
  logic [31:0]   m_rdt;
  logic [N-1:0]  m_ack;
  logic [N-1:0]  m_err;
  logic [N-1:0]  grant;
  logic [31:0]   s_adr;
  logic [31:0]   s_dat;
  logic [3:0]    s_sel;
  logic          s_we;
  logic          s_cyc;
  logic [31:0]   s_rdt;
  logic          s_ack;

  int n_tests = 0;
  int n_fail  = 0;

  servant_wb_rr_arbiter #(
    .NUM_MASTERS(N),
    .TIMEOUT    (4),
    .TO_WIDTH   (8)
  ) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_m_cyc(m_cyc),
    .i_m_we (m_we),
    .i_m_adr(m_adr),
    .i_m_dat(m_dat),
    .i_m_sel(m_sel),
    .o_m_rdt(m_rdt),
    .o_m_ack(m_ack),
    .o_m_err(m_err),
    .o_grant(grant),
    .o_s_adr(s_adr),
    .o_s_dat(s_dat),
    .o_s_sel(s_sel),
    .o_s_we (s_we),
    .o_s_cyc(s_cyc),
    .i_s_rdt(s_rdt),
    .i_s_ack(s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cyc;
    logic [2:0]  we;
    logic        ack;
    logic [31:0] rdt;
    logic [2:0]  eg;
    logic [2:0]  eack;
    logic [2:0]  eerr;
    logic [31:0] erdt;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] adr_tab[N];
  logic [31:0] dat_tab[N];
  logic [3:0]  sel_tab[N];

  function automatic vec_t mk(logic [2:0] cyc, logic [2:0] we, logic ack, logic [31:0] rdt,
                              logic [2:0] eg, logic [2:0] eack, logic [2:0] eerr,
                              logic [31:0] erdt);
    vec_t v;
    v.cyc = cyc; v.we = we; v.ack = ack; v.rdt = rdt;
    v.eg = eg; v.eack = eack; v.eerr = eerr; v.erdt = erdt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%08h, want 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    e_adr = '0; e_dat = '0; e_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (v.eg[k]) begin
        e_adr = adr_tab[k];
        e_dat = dat_tab[k];
        e_sel = sel_tab[k];
      end
    end
    check("grant", i, 32'(grant), 32'(v.eg));
    check("s_cyc", i, 32'(s_cyc), 32'(|(v.eg & v.cyc)));
    check("s_we",  i, 32'(s_we),  32'(|(v.eg & v.we)));
    check("s_adr", i, s_adr, e_adr);
    check("s_dat", i, s_dat, e_dat);
    check("s_sel", i, 32'(s_sel), 32'(e_sel));
    check("m_ack", i, 32'(m_ack), 32'(v.eack));
    check("m_err", i, 32'(m_err), 32'(v.eerr));
    if (v.eack != 3'b000) check("m_rdt", i, m_rdt, v.erdt);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      adr_tab[k] = 32'h100 + 32'h100 * k;
      dat_tab[k] = 32'hD0D0_0000 + k;
      sel_tab[k] = 4'b0001 << k;
      m_adr[k*32 +: 32] = adr_tab[k];
      m_dat[k*32 +: 32] = dat_tab[k];
      m_sel[k*4 +: 4]   = sel_tab[k];
    end

    // Fairness straight out of reset: 0,1,2,0,1,2, three cycles each.
    // The slave ack held high in IDLE must be ignored.
    for (int r = 0; r < 6; r++) begin
      logic [2:0] oh;
      oh = 3'b001 << (r % 3);
      vecs.push_back(mk(3'b111, 3'b000, 1'b1, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
      vecs.push_back(mk(3'b111, 3'b000, 1'b0, 32'h0, oh, 3'b000, 3'b000, 32'h0));
      vecs.push_back(mk(3'b111, 3'b000, 1'b1, 32'h1000 + r, oh, oh, 3'b000, 32'h1000 + r));
    end
    // Single ibus read.
    vecs.push_back(mk(3'b001, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b001, 3'b000, 1'b0, 32'h0, 3'b001, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b001, 3'b000, 1'b1, 32'hCAFEF00D, 3'b001, 3'b001, 3'b000,
                      32'hCAFEF00D));
    vecs.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    // dbus write timing out on the 4th GRANT cycle; rdt must be forced to 0.
    vecs.push_back(mk(3'b010, 3'b010, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    for (int c = 0; c < 3; c++)
      vecs.push_back(mk(3'b010, 3'b010, 1'b0, 32'hDEADBEEF, 3'b010, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b010, 3'b010, 1'b0, 32'hDEADBEEF, 3'b010, 3'b010, 3'b010, 32'h0));
    // Still requesting: slave sees cyc low, then dbus is re-arbitrated as new.
    vecs.push_back(mk(3'b010, 3'b010, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    for (int c = 0; c < 3; c++)
      vecs.push_back(mk(3'b010, 3'b010, 1'b0, 32'h0, 3'b010, 3'b000, 3'b000, 32'h0));
    // Ack on the timeout cycle wins: no error.
    vecs.push_back(mk(3'b010, 3'b010, 1'b1, 32'h12345678, 3'b010, 3'b010, 3'b000,
                      32'h12345678));
    vecs.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    // Abort by master 2, late ack dropped, then last (=1) still points at 2.
    vecs.push_back(mk(3'b100, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b100, 3'b000, 1'b0, 32'h0, 3'b100, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b100, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b000, 3'b000, 1'b1, 32'hBAD, 3'b000, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b111, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b111, 3'b000, 1'b0, 32'h0, 3'b100, 3'b000, 3'b000, 32'h0));
    vecs.push_back(mk(3'b111, 3'b000, 1'b1, 32'h55AA, 3'b100, 3'b100, 3'b000, 32'h55AA));
    vecs.push_back(mk(3'b000, 3'b000, 1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h0));

    // Reset state with every input active.
    nrst  = 1'b0;
    m_cyc = 3'b111;
    m_we  = 3'b111;
    s_ack = 1'b1;
    s_rdt = 32'hFFFF_FFFF;
    #3;
    check("rst_grant", 0, 32'(grant), 32'h0);
    check("rst_s_cyc", 0, 32'(s_cyc), 32'h0);
    check("rst_m_ack", 0, 32'(m_ack), 32'h0);
    check("rst_m_err", 0, 32'(m_err), 32'h0);
    check("rst_s_adr", 0, s_adr, 32'h0);
    check("rst_s_dat", 0, s_dat, 32'h0);
    check("rst_s_sel", 0, 32'(s_sel), 32'h0);
    check("rst_s_we",  0, 32'(s_we), 32'h0);
    @(negedge clk);
    nrst = 1'b1;

    // Each vector is one clock cycle: drive after the falling edge, check before the rise.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      m_cyc = vecs[i].cyc;
      m_we  = vecs[i].we;
      s_ack = vecs[i].ack;
      s_rdt = vecs[i].rdt;
      #2;
      check_vec(i, vecs[i]);
    end

    // Reset asserted in the middle of a GRANT cycle that is being acked.
    @(negedge clk);
    m_cyc = 3'b001;
    m_we  = 3'b000;
    s_ack = 1'b0;
    s_rdt = 32'h0;
    @(negedge clk);
    s_ack = 1'b1;
    s_rdt = 32'h7777_7777;
    #1;
    check("mid_grant", 0, 32'(grant), 32'h1);
    check("mid_ack",   0, 32'(m_ack), 32'h1);
    nrst = 1'b0;
    #1;
    check("arst_s_cyc", 0, 32'(s_cyc), 32'h0);
    check("arst_grant", 0, 32'(grant), 32'h0);
    check("arst_m_ack", 0, 32'(m_ack), 32'h0);
    s_ack = 1'b0;
    m_cyc = 3'b111;
    @(negedge clk);
    nrst = 1'b1;
    #2;
    check("post_idle", 0, 32'(grant), 32'h0);
    @(negedge clk);
    #2;
    check("post_first", 0, 32'(grant), 32'h1);
    check("post_s_adr", 0, s_adr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
